program_loader: RTL and testbench
=================================

# program_loader

Byte-stream boot loader that sits directly upstream of the pipelined CPU top level. It receives a command/data byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It drives the CPU's program-memory and data-memory load ports, and holds the CPU in reset via `cpu_rstn` until a run command arrives.

## Interface
- `BITS`, 32, word width; only 32 is supported (4 bytes per word).
- `PM_DEPTH`, 256, program memory depth in words.
- `DM_DEPTH`, 256, data memory depth in words.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rstn`  in  1  reset, synchronous, active-low.
- `byte_valid`  in  1  upstream byte present.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `pm_write_en`  out  1  program memory write strobe.
- `pm_write_address`  out  $clog2(PM_DEPTH)+2  program memory byte address; always word-aligned, bits [1:0]=0.
- `pm_data_in`  out  BITS  program word.
- `dm_write_en`  out  1  data memory write strobe.
- `dm_write_address`  out  $clog2(DM_DEPTH)  data memory word address.
- `dm_data_in_load`  out  BITS  data word.
- `cpu_rstn`  out  1  active-low reset to the CPU.
- `busy`  out  1  loader is not in IDLE.
- `error`  out  1  sticky flag: unknown command received.

## Operation
- A byte is accepted only when `byte_valid && byte_ready` at a rising edge.
- **Commands**, accepted in IDLE:
  - 0x50 'P': load program memory.
  - 0x44 'D': load data memory.
  - 0x47 'G': set `cpu_rstn`=1.
  - 0x48 'H': set `cpu_rstn`=0.
  - Any other byte: set `error`=1, stay in IDLE. Only `rstn` clears `error`.
- **Load sequence** after 'P' or 'D':
  - Two count bytes follow, high byte first, giving a 16-bit word count N.
  - Then 4N data bytes; each word is big-endian (first byte lands in [31:24]).
- **State machine:**
  - IDLE → CNT_HI on 'P' or 'D'. The target (PM or DM) is latched, `cpu_rstn` drops to 0 immediately, and the word address clears to 0.
  - CNT_HI → CNT_LO.
  - CNT_LO → DATA if N≠0. CNT_LO → IDLE if N=0, with no writes.
  - DATA collects 4 bytes in a byte counter that runs 0..3, then goes to WRITE.
  - WRITE lasts one cycle and asserts the selected strobe. It then decrements the remaining count and increments the word address. It goes → DATA if the remaining count is ≠0, else → IDLE.
  - 'G' and 'H' act in IDLE only, with no state change.
- **Address rules:**
  - Word addresses wrap modulo PM_DEPTH or DM_DEPTH; N > depth overwrites from 0.
  - `pm_write_address` = word address << 2.
- **Handshake:**
  - `byte_ready`=1 in every state except WRITE.
  - `byte_valid` may drop at any time, and the loader waits indefinitely in the current state.
- **Output behaviour:**
  - All outputs are registered.
  - Strobes are asserted only in WRITE. The non-selected strobe stays 0.
  - Address and data outputs hold their last values when idle.
  - `busy`=1 whenever state≠IDLE.
- **Reset** (`rstn`=0, including mid-load):
  - State→IDLE and the partial word is discarded.
  - Count, addresses, data and strobes → 0.
  - `cpu_rstn`=0, `busy`=0, `error`=0, `byte_ready`=0 during reset. `byte_ready` goes to 1 the first cycle after reset deasserts.

## Timing
- Fourth data byte accepted at edge t:
  - strobe, address and data valid in cycle t..t+1 (WRITE);
  - `byte_ready`=0 in that same cycle;
  - `byte_ready`=1 again from edge t+1.
- Per word: minimum 5 cycles (4 accept + 1 write).
- Program load of N words: minimum 3 + 5N cycles from the command byte to return to IDLE.
- 'P'/'D' accepted at edge t → `cpu_rstn`=0 from t.
- 'G' accepted at edge t → `cpu_rstn`=1 from t. The CPU sees reset released at edge t+1.
- Writes complete while `cpu_rstn`=0, so the CPU never fetches a partially loaded image.
- The strobe is one cycle wide per word, so no duplicate write occurs if `byte_valid` stays high.

## Test plan
- **Reset values:** after reset, `cpu_rstn`=0, `busy`=0, `error`=0, strobes=0, `byte_ready`=1 on the first cycle after release.
- **Program load:** stream 50 00 02 20 08 00 05 AC 01 00 04 → two `pm_write_en` pulses:
  - address 0x000, data 0x20080005;
  - address 0x004, data 0xAC010004;
  - then `busy`=0, and `cpu_rstn` still 0 until 'G' (0x47), after which `cpu_rstn`=1.
- **Data load with stalls:** stream 44 00 01 DE AD BE EF with `byte_valid` deasserted for 3 random cycles between bytes → exactly one `dm_write_en`, address 0, data 0xDEADBEEF; `pm_write_en` never asserted.
- **Boundary cases:**
  - 'P' with N=0 (50 00 00) → no strobe, returns to IDLE, a following 'G' is accepted.
  - 'D' with N=DM_DEPTH+1 → last word written to address 0.
- **Error and run control:**
  - Byte 0x13 in IDLE → `error`=1; a following 'P' load still works and `error` stays 1.
  - While running (`cpu_rstn`=1), a 'P' command → `cpu_rstn`=0 on the accept edge.
- **Reset mid-load:** assert `rstn`=0 after the 2nd data byte of a word → no strobe. A fresh load then writes starting at address 0 with correct data.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader for the pipelined CPU.
// Accepts command/data bytes over a valid/ready handshake, assembles
// big-endian words and writes them into program or data memory, and holds
// the CPU in reset (cpu_rstn) until a 'G' command arrives.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   byte_valid/data      upstream byte stream
//   byte_ready           loader accepts a byte this cycle
//   pm_write_*           program memory load port (byte address, word aligned)
//   dm_write_*           data memory load port (word address)
//   cpu_rstn             active-low reset to the CPU
//   busy                 loader not idle
//   error                sticky unknown-command flag
module program_loader #(
  parameter int BITS     = 32,
  parameter int PM_DEPTH = 256,
  parameter int DM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  output logic                          byte_ready,
  output logic                          pm_write_en,
  output logic [$clog2(PM_DEPTH)+1:0]   pm_write_address,
  output logic [BITS-1:0]               pm_data_in,
  output logic                          dm_write_en,
  output logic [$clog2(DM_DEPTH)-1:0]   dm_write_address,
  output logic [BITS-1:0]               dm_data_in_load,
  output logic                          cpu_rstn,
  output logic                          busy,
  output logic                          error
);

  localparam int PAW = $clog2(PM_DEPTH);
  localparam int DAW = $clog2(DM_DEPTH);
  localparam int WAW = (PAW > DAW) ? PAW : DAW;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE
  } state_t;

  state_t           state_q, state_d;
  logic             tgt_dm_q, tgt_dm_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [BITS-1:0]  word_q, word_d;
  logic [WAW-1:0]   waddr_q, waddr_d;
  logic             rdy_q, rdy_d;
  logic             pm_we_q, pm_we_d;
  logic [PAW+1:0]   pm_addr_q, pm_addr_d;
  logic [BITS-1:0]  pm_data_q, pm_data_d;
  logic             dm_we_q, dm_we_d;
  logic [DAW-1:0]   dm_addr_q, dm_addr_d;
  logic [BITS-1:0]  dm_data_q, dm_data_d;
  logic             cpu_rstn_q, cpu_rstn_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             accept;
  logic [BITS-1:0]  word_next;
  logic [15:0]      cnt_dec;
  logic [WAW-1:0]   waddr_last;

  assign accept     = byte_valid && rdy_q;
  assign word_next  = {word_q[BITS-9:0], byte_data};
  assign cnt_dec    = cnt_q - 16'd1;
  assign waddr_last = tgt_dm_q ? WAW'(DM_DEPTH - 1) : WAW'(PM_DEPTH - 1);

  always_comb begin
    state_d    = state_q;
    tgt_dm_d   = tgt_dm_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    waddr_d    = waddr_q;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_data_d  = pm_data_q;
    dm_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_data_d  = dm_data_q;
    cpu_rstn_d = cpu_rstn_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (byte_data)
            8'h50, 8'h44: begin
              tgt_dm_d   = (byte_data == 8'h44);
              cpu_rstn_d = 1'b0;
              waddr_d    = '0;
              state_d    = S_CNT_HI;
            end
            8'h47:   cpu_rstn_d = 1'b1;
            8'h48:   cpu_rstn_d = 1'b0;
            default: err_d      = 1'b1;
          endcase
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          cnt_d   = {byte_data, cnt_q[7:0]};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_d   = {cnt_q[15:8], byte_data};
          bcnt_d  = '0;
          state_d = ({cnt_q[15:8], byte_data} == 16'd0) ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = word_next;
          if (bcnt_q == 2'd3) begin
            // Strobe, address and data are registered on the same edge that
            // accepts the last byte, so they are valid throughout WRITE.
            bcnt_d  = '0;
            state_d = S_WRITE;
            if (tgt_dm_q) begin
              dm_we_d   = 1'b1;
              dm_addr_d = waddr_q[DAW-1:0];
              dm_data_d = word_next;
            end else begin
              pm_we_d   = 1'b1;
              pm_addr_d = {waddr_q[PAW-1:0], 2'b00};
              pm_data_d = word_next;
            end
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_dec;
        waddr_d = (waddr_q == waddr_last) ? '0 : waddr_q + WAW'(1);
        state_d = (cnt_dec != 16'd0) ? S_DATA : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d  = (state_d != S_WRITE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      tgt_dm_q   <= 1'b0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      waddr_q    <= '0;
      rdy_q      <= 1'b0;
      pm_we_q    <= 1'b0;
      pm_addr_q  <= '0;
      pm_data_q  <= '0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_data_q  <= '0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_dm_q   <= tgt_dm_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      waddr_q    <= waddr_d;
      rdy_q      <= rdy_d;
      pm_we_q    <= pm_we_d;
      pm_addr_q  <= pm_addr_d;
      pm_data_q  <= pm_data_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_data_q  <= dm_data_d;
      cpu_rstn_q <= cpu_rstn_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign byte_ready       = rdy_q;
  assign pm_write_en      = pm_we_q;
  assign pm_write_address = pm_addr_q;
  assign pm_data_in       = pm_data_q;
  assign dm_write_en      = dm_we_q;
  assign dm_write_address = dm_addr_q;
  assign dm_data_in_load  = dm_data_q;
  assign cpu_rstn         = cpu_rstn_q;
  assign busy             = busy_q;
  assign error            = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader.
// A transaction-level model predicts the list of memory writes and the
// cpu_rstn / error flags from the command stream; a monitor collects the
// writes the DUT actually performs and the two lists are compared.
module tb_program_loader;

  localparam int PM_DEPTH = 256;
  localparam int DM_DEPTH = 256;

  logic        clk = 1'b0;
  logic        rstn;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        pm_write_en;
  logic [9:0]  pm_write_address;
  logic [31:0] pm_data_in;
  logic        dm_write_en;
  logic [7:0]  dm_write_address;
  logic [31:0] dm_data_in_load;
  logic        cpu_rstn;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  program_loader #(.BITS(32), .PM_DEPTH(PM_DEPTH), .DM_DEPTH(DM_DEPTH)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .pm_write_en      (pm_write_en),
    .pm_write_address (pm_write_address),
    .pm_data_in       (pm_data_in),
    .dm_write_en      (dm_write_en),
    .dm_write_address (dm_write_address),
    .dm_data_in_load  (dm_data_in_load),
    .cpu_rstn         (cpu_rstn),
    .busy             (busy),
    .error            (error)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // write record: {15'b0, is_dm, address, data}
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [31:0] tx_words[$];
  logic        exp_cpu_rstn;
  logic        exp_error;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pm_write_en) obs_q.push_back({15'd0, 1'b0, 16'(pm_write_address), pm_data_in});
    if (dm_write_en) obs_q.push_back({15'd0, 1'b1, 16'(dm_write_address), dm_data_in_load});
  end

  // Command-level reference behaviour for bytes accepted in IDLE.
  task automatic model_cmd(input logic [7:0] b);
    case (b)
      8'h50, 8'h44: exp_cpu_rstn = 1'b0;
      8'h47:        exp_cpu_rstn = 1'b1;
      8'h48:        exp_cpu_rstn = 1'b0;
      default:      exp_error    = 1'b1;
    endcase
  endtask

  // Present one byte with optional idle stall; returns #1 after accept edge.
  task automatic send_byte(input logic [7:0] b, input int max_stall);
    int stall;
    stall = (max_stall == 0) ? 0 : int'($urandom_range(max_stall, 0));
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (stall) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int g = 0; g < 16 && !byte_ready; g++) @(negedge clk);
    if (!byte_ready) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_write"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Full load of tx_words into PM or DM.
  task automatic do_load(input bit dm, input int max_stall, input string tag);
    int          n;
    logic [15:0] nn;
    logic [31:0] w;
    n  = tx_words.size();
    nn = 16'(n);
    send_byte(dm ? 8'h44 : 8'h50, max_stall);
    model_cmd(dm ? 8'h44 : 8'h50);
    check({tag, "_cmd_cpu_rstn"}, 64'(cpu_rstn), 64'(exp_cpu_rstn));
    check({tag, "_cmd_busy"}, 64'(busy), 64'd1);
    send_byte(nn[15:8], max_stall);
    send_byte(nn[7:0], max_stall);
    for (int i = 0; i < n; i++) begin
      w = tx_words[i];
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], max_stall);
      if (dm) exp_q.push_back({15'd0, 1'b1, 16'(i % DM_DEPTH), w});
      else    exp_q.push_back({15'd0, 1'b0, 16'((i % PM_DEPTH) * 4), w});
      if (i < 2) begin
        check({tag, "_strobe"}, 64'(dm ? dm_write_en : pm_write_en), 64'd1);
        check({tag, "_other_strobe"}, 64'(dm ? pm_write_en : dm_write_en), 64'd0);
        check({tag, "_ready_in_write"}, 64'(byte_ready), 64'd0);
      end
    end
    if (n > 0) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_ready_after"}, 64'(byte_ready), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_cpu_rstn_after"}, 64'(cpu_rstn), 64'(exp_cpu_rstn));
    compare_writes(tag);
    tx_words.delete();
  endtask

  task automatic send_cmd(input logic [7:0] b, input string tag);
    send_byte(b, 2);
    model_cmd(b);
    check({tag, "_cpu_rstn"}, 64'(cpu_rstn), 64'(exp_cpu_rstn));
    check({tag, "_error"}, 64'(error), 64'(exp_error));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rstn       = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_rst_cpu_rstn"}, 64'(cpu_rstn), 64'd0);
    check({tag, "_rst_busy"}, 64'(busy), 64'd0);
    check({tag, "_rst_error"}, 64'(error), 64'd0);
    check({tag, "_rst_strobes"}, 64'({pm_write_en, dm_write_en}), 64'd0);
    rstn = 1'b1;
    exp_cpu_rstn = 1'b0;
    exp_error    = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rel_ready"}, 64'(byte_ready), 64'd1);
    check({tag, "_rel_cpu_rstn"}, 64'(cpu_rstn), 64'd0);
    obs_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    rstn       = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    exp_cpu_rstn = 1'b0;
    exp_error    = 1'b0;

    do_reset("init");

    // Program load from the directed stream, then run.
    tx_words.push_back(32'h20080005);
    tx_words.push_back(32'hAC010004);
    do_load(1'b0, 0, "pload");
    send_cmd(8'h47, "go");

    // Data load with stalls between bytes.
    tx_words.push_back(32'hDEADBEEF);
    do_load(1'b1, 3, "dload");

    // Zero-length program load, then run.
    do_load(1'b0, 1, "pzero");
    send_cmd(8'h47, "go_after_zero");

    // Data load longer than the memory: last word lands at address 0.
    for (int i = 0; i < DM_DEPTH + 1; i++) tx_words.push_back($urandom);
    do_load(1'b1, 0, "dwrap");

    // Unknown command, then a load still works with error held.
    send_cmd(8'h13, "badcmd");
    for (int i = 0; i < 3; i++) tx_words.push_back($urandom);
    do_load(1'b0, 2, "pload_err");
    check("error_sticky", 64'(error), 64'd1);

    // Load command while running drops cpu_rstn on the accept edge.
    send_cmd(8'h47, "go_run");
    tx_words.push_back($urandom);
    do_load(1'b0, 1, "pload_run");

    // Reset in the middle of a word: nothing written, then a clean load.
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    do_reset("midload");
    check("midload_no_write", 64'(obs_q.size()), 64'd0);
    tx_words.push_back(32'hCAFEF00D);
    tx_words.push_back(32'h01234567);
    do_load(1'b0, 1, "pload_fresh");

    // Randomized command mix.
    for (int t = 0; t < 24; t++) begin
      r = int'($urandom_range(4, 0));
      case (r)
        0, 1: begin
          for (int i = 0; i < int'($urandom_range(5, 1)); i++) tx_words.push_back($urandom);
          do_load(r == 1, 2, "rnd_load");
        end
        2: send_cmd(8'h47, "rnd_go");
        3: send_cmd(8'h48, "rnd_halt");
        default: begin
          b = 8'($urandom);
          if (b == 8'h50 || b == 8'h44 || b == 8'h47 || b == 8'h48) b = 8'hFF;
          send_cmd(b, "rnd_junk");
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
